// File: rtl/router_pkg.sv
// Shared types and constants for the packet router control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

  localparam int         NUM_PORTS       = 3;
  localparam logic [1:0] ADDR_INVALID    = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 30;
  localparam int         LEN_W           = 6;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    DROP
  } state_t;

  // One-hot port select; the invalid address maps to no port at all.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    sel = '0;
    case (addr)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port stale-data timer: pulses o_soft_reset when a FIFO holds unread data too long.
// Latency: pulse registered on the TIMEOUT-th consecutive unread-valid edge.
// Backpressure: none; any read or an empty FIFO restarts the count.
module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_fifo_empty,
  input  logic i_read_enb,
  output logic o_soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;

  // Count unread-valid cycles; fire a single-cycle flush on reaching TIMEOUT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (i_fifo_empty || i_read_enb) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_soft_reset <= 1'b0;
    end
  end

  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_ctrl.sv
// Router control FSM: decodes the header, steers bytes into one of three FIFOs, checks length.
// Latency: header written one cycle after decode; payload written in the cycle it is presented.
// Backpressure: busy holds the sender on header, FIFO-full, parity and check cycles.
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full_0,
  input  logic       fifo_full_1,
  input  logic       fifo_full_2,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       err
);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_payload_cnt;
  logic               r_drop_err;

  // Padded to four entries so a 2-bit address indexes them exactly.
  logic [3:0]         w_full4;
  logic [3:0]         w_empty4;
  logic [3:0]         w_srst4;
  logic [2:0]         w_empty;
  logic [2:0]         w_rd;
  logic [2:0]         w_srst;
  logic               w_full_sel;
  logic               w_empty_sel;
  logic               w_srst_sel;
  logic               w_write;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_latch;
  logic               w_len_err;

  assign w_empty  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_rd     = {read_enb_2, read_enb_1, read_enb_0};
  assign w_full4  = {1'b0, fifo_full_2, fifo_full_1, fifo_full_0};
  assign w_empty4 = {1'b0, w_empty};
  assign w_srst4  = {1'b0, w_srst};

  assign w_full_sel  = w_full4[r_addr];
  assign w_empty_sel = w_empty4[r_addr];
  assign w_srst_sel  = w_srst4[r_addr];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock        (clock),
      .resetn       (resetn),
      .i_fifo_empty (w_empty[g]),
      .i_read_enb   (w_rd[g]),
      .o_soft_reset (w_srst[g])
    );
  end

  assign soft_reset_0 = w_srst[0];
  assign soft_reset_1 = w_srst[1];
  assign soft_reset_2 = w_srst[2];

  // State register plus the header fields captured at decode.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr <= data_in[1:0];
        r_len  <= data_in[7:2];
      end
    end
  end

  // Payload byte counter; saturates rather than wrapping on oversize packets.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_payload_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_payload_cnt <= '0;
    end else if (w_cnt_inc && (r_payload_cnt != '1)) begin
      r_payload_cnt <= r_payload_cnt + LEN_W'(1);
    end
  end

  // Registered so the invalid-address error shows as a state-driven pulse in the first DROP cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= (r_state == DECODE_ADDRESS) && pkt_valid && (data_in[1:0] == ADDR_INVALID);
    end
  end

  // Next-state and Moore-style outputs; a port flush aborts any in-flight packet to that port.
  always_comb begin
    w_next      = r_state;
    w_write     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_latch     = 1'b0;
    w_len_err   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    busy        = 1'b0;
    case (r_state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        if (pkt_valid) begin
          if (data_in[1:0] == ADDR_INVALID) begin
            w_next = DROP;
          end else begin
            w_latch = 1'b1;
            w_next  = w_empty4[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (w_empty_sel) w_next = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        w_write   = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state = 1'b1;
        if (w_full_sel) begin
          w_next = FIFO_FULL_STATE;
        end else if (pkt_valid) begin
          w_write   = 1'b1;
          w_cnt_inc = 1'b1;
        end else begin
          w_next = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        busy       = 1'b1;
        full_state = 1'b1;
        if (!w_full_sel) w_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        busy      = 1'b1;
        laf_state = 1'b1;
        w_write   = 1'b1;
        if (pkt_valid) begin
          w_cnt_inc = 1'b1;
          w_next    = LOAD_DATA;
        end else begin
          w_next = CHECK_PARITY_ERROR;
        end
      end
      LOAD_PARITY: begin
        busy    = 1'b1;
        w_write = 1'b1;
        w_next  = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        busy        = 1'b1;
        rst_int_reg = 1'b1;
        w_len_err   = (r_payload_cnt != r_len);
        w_next      = w_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      DROP: begin
        if (!pkt_valid) w_next = DECODE_ADDRESS;
      end
      default: begin
        w_next = DECODE_ADDRESS;
      end
    endcase
    if (w_srst_sel && (r_state != DECODE_ADDRESS) && (r_state != DROP)) begin
      w_next = DECODE_ADDRESS;
    end
  end

  assign write_enb = w_write ? port_onehot(r_addr) : 3'b000;
  assign err       = w_len_err | r_drop_err;

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30: consecutive unread-valid cycles before a port soft reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pkt_valid  input  1  high for header and payload bytes, low for the parity byte.
REQ-005 data_in  input  8  header byte: [1:0] destination, [7:2] payload length.
REQ-006 fifo_full_0/1/2  input  1 each  destination FIFO full.
REQ-007 fifo_empty_0/1/2  input  1 each  destination FIFO empty.
REQ-008 read_enb_0/1/2  input  1 each  consumer read strobes.
REQ-009 write_enb  output  3  one-hot FIFO write enable, bit n selects port n.
REQ-010 detect_add, lfd_state, ld_state, laf_state, full_state  output  1 each  state flags for the datapath.
REQ-011 rst_int_reg  output  1  one-cycle pulse that clears the datapath parity register.
REQ-012 busy  output  1  sender must hold data_in and pkt_valid while high.
REQ-013 soft_reset_0/1/2  output  1 each  one-cycle FIFO flush pulse.
REQ-014 err  output  1  one-cycle pulse on an invalid address or a length mismatch.

Function
REQ-015 Moore FSM states: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP.
REQ-016 DECODE_ADDRESS (detect_add=1, busy=0), when pkt_valid is high:
- addr 3: go to DROP and pulse err.
- fifo_empty[addr] high: go to LOAD_FIRST_DATA.
- otherwise: go to WAIT_TILL_EMPTY.
- In every valid-address case, latch addr_r=data_in[1:0] and len_r=data_in[7:2].
REQ-017 WAIT_TILL_EMPTY: busy=1, no writes; go to LOAD_FIRST_DATA when fifo_empty[addr_r] is high.
REQ-018 LOAD_FIRST_DATA: busy=1, lfd_state=1, write_enb[addr_r]=1 (header written); clear payload_cnt; go to LOAD_DATA.
REQ-019 LOAD_DATA (busy=0, ld_state=1):
- fifo_full[addr_r] high: go to FIFO_FULL_STATE with no write.
- else pkt_valid high: write, increment payload_cnt, stay.
- else: go to LOAD_PARITY.
REQ-020 FIFO_FULL_STATE: busy=1, full_state=1, no write; go to LOAD_AFTER_FULL when fifo_full[addr_r] is low.
REQ-021 LOAD_AFTER_FULL: busy=1, laf_state=1, writes the held byte.
- If the held byte was payload (pkt_valid=1), increment payload_cnt; next state is LOAD_DATA.
- If pkt_valid=0, the held byte was parity; next state is CHECK_PARITY_ERROR.
REQ-022 LOAD_PARITY: busy=1, writes the parity byte; go to CHECK_PARITY_ERROR.
REQ-023 CHECK_PARITY_ERROR: busy=1, rst_int_reg=1.
- Pulse err if payload_cnt != len_r.
- Go to FIFO_FULL_STATE if fifo_full[addr_r] is high, else DECODE_ADDRESS.
REQ-024 DROP: busy=0, no writes; return to DECODE_ADDRESS on the first cycle with pkt_valid=0 (parity consumed).
REQ-025 payload_cnt is 6 bits and saturates at 63; it never wraps.
REQ-026 Per-port timer:
- Counts while fifo_empty_n=0 and read_enb_n=0.
- Clears on read_enb_n or fifo_empty_n.
- On reaching TIMEOUT, pulses soft_reset_n for one cycle and clears.
REQ-027 soft_reset for port addr_r in any state other than DECODE_ADDRESS or DROP forces DECODE_ADDRESS next cycle; this takes priority over all other transitions.
REQ-028 Outputs are a function of the registered state, addr_r, pkt_valid and fifo_full only.
REQ-029 At most one write_enb bit is high in any cycle.

Reset
REQ-030 While resetn is low:
- state=DECODE_ADDRESS; addr_r, len_r, payload_cnt and all timers are 0.
- All outputs are 0, except detect_add=1.
REQ-031 Reset asserted mid-packet aborts the packet with no further writes after reset.

Structure
REQ-032 Shared package router_pkg holds the state enumeration, NUM_PORTS=3, ADDR_INVALID=2'b11 and default TIMEOUT.
REQ-033 One sub-module, router_timeout (a single-port timer), is instantiated three times.

Verification
REQ-034 Header 8'h0D (len 3, port 1), empty FIFO, then 3 payload bytes and parity -> write_enb=3'b010 for 5 cycles; err=0; rst_int_reg pulses once.
REQ-035 Header 8'h03 (port 3) -> err pulses; write_enb stays 0 through the whole packet; FSM returns to DECODE_ADDRESS.
REQ-036 fifo_full_0 asserted on the 2nd payload byte -> busy=1 in FIFO_FULL_STATE; on release, LOAD_AFTER_FULL writes the held byte; payload_cnt is correct.
REQ-037 Port 2 left unread with data for 30 cycles -> soft_reset_2 pulses on cycle 30; a packet in progress to port 2 aborts to DECODE_ADDRESS.
REQ-038 Header len 4, but pkt_valid drops after 2 payload bytes -> err pulses in CHECK_PARITY_ERROR.
